// File: rtl/ram_march_sequencer.sv
// March C- sequencer for BIST: runs M0..M5 over the RAM, compares each read against the background.
// Latency 11*N cycles per passing run; no backpressure, and start is ignored while busy.
module ram_march_sequencer #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              b_clk,
  input  logic              b_rst,
  input  logic              start,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  output logic              ram_re,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [2:0]        fail_elem
);
  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_CHECK, S_DONE} state_t;

  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;
  localparam logic [2:0]        ELEM_LAST = 3'd5;

  state_t            state_q, state_d;
  logic [2:0]        elem_q, elem_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
  logic [2:0]        fail_elem_q, fail_elem_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic              fail_q, fail_d;

  logic              elem_down, elem_end, rd_match, chk_we;
  logic [DATA_W-1:0] exp_dat;
  logic [2:0]        elem_nxt;

  always_comb begin
    elem_down = (elem_q == 3'd3) || (elem_q == 3'd4);
    elem_end  = elem_down ? (addr_q == '0) : (addr_q == ADDR_LAST);
    exp_dat   = elem_q[0] ? '0 : '1;
    rd_match  = (ram_rdata == exp_dat);
    // A failing word is left untouched, so the write in CHECK is qualified by the compare.
    chk_we    = (state_q == S_CHECK) && rd_match && (elem_q != ELEM_LAST);
    elem_nxt  = elem_q + 3'd1;
  end

  always_comb begin
    state_d     = state_q;
    elem_d      = elem_q;
    addr_d      = addr_q;
    fail_addr_d = fail_addr_q;
    fail_elem_d = fail_elem_q;
    pass_d      = pass_q;
    fail_d      = fail_q;
    done_d      = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d     = S_WRITE;
          elem_d      = 3'd0;
          addr_d      = '0;
          pass_d      = 1'b0;
          fail_d      = 1'b0;
          fail_addr_d = '0;
          fail_elem_d = 3'd0;
        end
      end
      S_WRITE: begin
        if (addr_q == ADDR_LAST) begin
          elem_d  = 3'd1;
          addr_d  = '0;
          state_d = S_READ;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      S_READ: state_d = S_CHECK;
      S_CHECK: begin
        if (!rd_match) begin
          fail_d      = 1'b1;
          fail_addr_d = addr_q;
          fail_elem_d = elem_q;
          done_d      = 1'b1;
          state_d     = S_DONE;
        end else if (elem_end) begin
          if (elem_q == ELEM_LAST) begin
            pass_d  = 1'b1;
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            elem_d  = elem_nxt;
            addr_d  = ((elem_nxt == 3'd3) || (elem_nxt == 3'd4)) ? ADDR_LAST : '0;
            state_d = S_READ;
          end
        end else begin
          addr_d  = elem_down ? addr_q - 1'b1 : addr_q + 1'b1;
          state_d = S_READ;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge b_clk or posedge b_rst) begin
    if (b_rst) begin
      state_q     <= S_IDLE;
      elem_q      <= 3'd0;
      addr_q      <= '0;
      fail_addr_q <= '0;
      fail_elem_q <= 3'd0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      elem_q      <= elem_d;
      addr_q      <= addr_d;
      fail_addr_q <= fail_addr_d;
      fail_elem_q <= fail_elem_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      fail_q      <= fail_d;
    end
  end

  // Address and data are forced to zero whenever neither strobe is active.
  always_comb begin
    ram_we    = (state_q == S_WRITE) || chk_we;
    ram_re    = (state_q == S_READ);
    ram_addr  = (ram_we || ram_re) ? addr_q : '0;
    ram_wdata = chk_we ? ~exp_dat : '0;
    busy      = (state_q == S_WRITE) || (state_q == S_READ) || (state_q == S_CHECK);
  end

  assign done      = done_q;
  assign pass      = pass_q;
  assign fail      = fail_q;
  assign fail_addr = fail_addr_q;
  assign fail_elem = fail_elem_q;

endmodule
